// File: rtl/wrap_tester_if.sv
// Host-control and wrapped-channel signals of the wrap tester.
// slave is the tester side; master is the host/plug side that drives stimulus and sense.
interface wrap_tester_if #(
  parameter int ERR_W  = 16,
  parameter int ITER_W = 16
);
  logic              start;
  logic              stop;
  logic [1:0]        pattern_mode;
  logic [18:0]       fixed_pattern;
  logic [ITER_W-1:0] iterations;
  logic              frontend_enable;
  logic [18:0]       a_drive;
  logic              a_operational_out;
  logic [18:0]       a_sense;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [18:0]       fail_mask;
  logic [ITER_W-1:0] iter_count;
  logic              parity_err;

  modport slave (
    input  start, stop, pattern_mode, fixed_pattern, iterations, a_sense,
    output frontend_enable, a_drive, a_operational_out, busy, done, pass,
           err_count, fail_mask, iter_count, parity_err
  );

  modport master (
    output start, stop, pattern_mode, fixed_pattern, iterations, a_sense,
    input  frontend_enable, a_drive, a_operational_out, busy, done, pass,
           err_count, fail_mask, iter_count, parity_err
  );
endinterface

// File: rtl/wrap_tester.sv
// Parallel Channel wrap-plug tester: drive pattern, settle, compare synchronised sense, accumulate errors.
// WRAP_TESTER_PARITY_GEN_EN: generate odd Bus Out parity on bit 18 and check Bus In parity instead of comparing it.
module wrap_tester #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          ERR_W         = 16,
  parameter int          ITER_W        = 16,
  parameter logic [18:0] LFSR_SEED     = 19'h00001
) (
  input  logic         clk,
  input  logic         reset_n,
  wrap_tester_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  localparam int            CW          = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [18:0]       sync1_q, sync2_q;
  logic [18:0]       drive_q, drive_d;
  logic [18:0]       lfsr_q, lfsr_d;
  logic [4:0]        walk_q, walk_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [18:0]       mask_q, mask_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              pass_q, pass_d;
  logic              par_q, par_d;

  logic [18:0] walk_pat, pat_raw, pattern, diff;
  logic        par_bad;

  always_comb begin
    walk_pat = 19'd1 << walk_q;
    case (mode_q)
      2'd0:    pat_raw = walk_pat;
      2'd1:    pat_raw = ~walk_pat;
      2'd2:    pat_raw = lfsr_q;
      default: pat_raw = bus.fixed_pattern;
    endcase
`ifdef WRAP_TESTER_PARITY_GEN_EN
    pattern = {~^pat_raw[17:10], pat_raw[17:0]};
    diff    = (sync2_q ^ drive_q) & 19'h3FFFF;
    // Odd parity over Bus In P and Bus In 7..0 means the nine bits XOR to 1.
    par_bad = ~^sync2_q[18:10];
`else
    pattern = pat_raw;
    diff    = sync2_q ^ drive_q;
    par_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    drive_d = drive_q;
    lfsr_d  = lfsr_q;
    walk_d  = walk_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    iter_d  = iter_q;
    pass_d  = pass_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          err_d   = '0;
          mask_d  = '0;
          iter_d  = '0;
          pass_d  = 1'b0;
          par_d   = 1'b0;
          lfsr_d  = LFSR_SEED;
          walk_d  = '0;
          mode_d  = bus.pattern_mode;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.stop) begin
          state_d = DONE;
        end else begin
          drive_d = pattern;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.stop)                   state_d = DONE;
        else if (cnt_q == SETTLE_LAST)  state_d = CHECK;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      CHECK: begin
        mask_d = mask_q | diff;
        if (diff != '0 && err_q != '1) err_d = err_q + 1'b1;
        if (par_bad)                   par_d = 1'b1;
        iter_d = iter_q + 1'b1;
        lfsr_d = {lfsr_q[17:0], lfsr_q[18] ^ lfsr_q[17] ^ lfsr_q[16] ^ lfsr_q[13]};
        walk_d = (walk_q == 5'd18) ? 5'd0 : walk_q + 5'd1;
        if (bus.stop || (bus.iterations != '0 && iter_d == bus.iterations))
          state_d = DONE;
        else
          state_d = DRIVE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Results are settled on entry to DONE so they are valid alongside the done pulse.
    if (state_d == DONE && state_q != DONE) begin
      drive_d = '0;
      pass_d  = (err_d == '0) && !par_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      drive_q <= '0;
      lfsr_q  <= LFSR_SEED;
      walk_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      iter_q  <= '0;
      pass_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.a_sense;
      sync2_q <= sync1_q;
      drive_q <= drive_d;
      lfsr_q  <= lfsr_d;
      walk_q  <= walk_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      iter_q  <= iter_d;
      pass_q  <= pass_d;
      par_q   <= par_d;
    end
  end

  assign bus.busy              = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign bus.frontend_enable   = bus.busy;
  assign bus.done              = (state_q == DONE);
  assign bus.a_drive           = drive_q;
  assign bus.a_operational_out = 1'b0;
  assign bus.pass              = pass_q;
  assign bus.err_count         = err_q;
  assign bus.fail_mask         = mask_q;
  assign bus.iter_count        = iter_q;
`ifdef WRAP_TESTER_PARITY_GEN_EN
  assign bus.parity_err        = par_q;
`else
  assign bus.parity_err        = 1'b0;
`endif

endmodule
